// File: rtl/uart_tb_pkg.sv
// Shared types and constants for the UART RX scoreboard.
package uart_tb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RX,
        HALT
    } t_sb_state;

    localparam int C_PAR_NONE = 0;
    localparam int C_PAR_EVEN = 1;
    localparam int C_PAR_ODD  = 2;

endpackage

// File: rtl/sync_fifo_sb.sv
// Synchronous show-ahead FIFO holding the expected byte queue.
module sync_fifo_sb #(
    parameter int G_WIDTH = 8,
    parameter int G_DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [G_WIDTH-1:0]         wr_data,
    output logic [G_WIDTH-1:0]         rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(G_DEPTH):0]   level
);

    localparam int AW = $clog2(G_DEPTH);
    localparam int LW = AW + 1;

    logic [G_WIDTH-1:0] mem [G_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               push_en;
    logic               pop_en;

    assign full    = level == LW'(G_DEPTH);
    assign empty   = level == '0;
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push_en) - LW'(pop_en);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en && !(rst || flush)) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_scoreboard.sv
// In-order compare of received UART bytes against an expected queue,
// with parity, unexpected-byte and timeout event reporting.
module uart_rx_scoreboard
    import uart_tb_pkg::*;
#(
    parameter int G_DATA_WIDTH     = 8,
    parameter int G_FIFO_DEPTH     = 16,
    parameter int G_PARITY         = 0,
    parameter int G_TIMEOUT_CYCLES = 200000,
    parameter int G_STOP_ON_ERR    = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_clr,
    input  logic                            i_exp_valid,
    input  logic [G_DATA_WIDTH-1:0]         i_exp_data,
    output logic                            o_exp_ready,
    input  logic                            i_rx_done,
    input  logic [G_DATA_WIDTH-1:0]         i_rx_data,
    input  logic                            i_parity_rcvd,
    output logic                            o_match,
    output logic                            o_mismatch,
    output logic                            o_parity_err,
    output logic                            o_unexpected,
    output logic                            o_timeout,
    output logic                            o_overflow,
    output logic                            o_halted,
    output logic [G_DATA_WIDTH-1:0]         o_last_rcvd,
    output logic [G_DATA_WIDTH-1:0]         o_last_exp,
    output logic [15:0]                     o_nb_ok,
    output logic [15:0]                     o_nb_err,
    output logic [$clog2(G_FIFO_DEPTH):0]   o_level
);

    localparam int          LW         = $clog2(G_FIFO_DEPTH) + 1;
    localparam logic [31:0] C_TMO_LAST = 32'(G_TIMEOUT_CYCLES - 1);

    t_sb_state               state;
    logic [31:0]             tmo_cnt;
    logic [G_DATA_WIDTH-1:0] head;
    logic                    full;
    logic                    empty;
    logic                    push_en;
    logic                    pop;
    logic                    rx_live;
    logic                    in_wait;
    logic                    cmp;
    logic                    unexp;
    logic                    tmo_hit;
    logic                    data_ne;
    logic                    par_exp;
    logic                    par_bad;
    logic [1:0]              n_err;
    logic [16:0]             err_sum;

    sync_fifo_sb #(
        .G_WIDTH (G_DATA_WIDTH),
        .G_DEPTH (G_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (i_clr),
        .push    (i_exp_valid),
        .pop     (pop),
        .wr_data (i_exp_data),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (o_level)
    );

    assign o_exp_ready = !full;
    assign o_halted    = state == HALT;
    assign push_en     = i_exp_valid && !full;

    assign rx_live = i_rx_done && state != HALT;
    assign in_wait = state == WAIT_RX && !empty;
    assign cmp     = rx_live && in_wait;
    assign unexp   = rx_live && !in_wait;
    assign tmo_hit = G_TIMEOUT_CYCLES != 0 && in_wait && !i_rx_done
                     && tmo_cnt == C_TMO_LAST;
    assign data_ne = i_rx_data != head;
    assign par_exp = (G_PARITY == C_PAR_ODD) ? ~^i_rx_data : ^i_rx_data;
    assign par_bad = G_PARITY != C_PAR_NONE && rx_live
                     && i_parity_rcvd != par_exp;
    assign pop     = cmp || tmo_hit;

    // A byte may be both a data mismatch and a parity error: up to +2.
    assign n_err   = 2'(cmp && data_ne) + 2'(par_bad) + 2'(unexp) + 2'(tmo_hit);
    assign err_sum = {1'b0, o_nb_err} + 17'(n_err);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            state        <= IDLE;
            tmo_cnt      <= '0;
            o_match      <= 1'b0;
            o_mismatch   <= 1'b0;
            o_parity_err <= 1'b0;
            o_unexpected <= 1'b0;
            o_timeout    <= 1'b0;
            o_overflow   <= 1'b0;
            o_last_rcvd  <= '0;
            o_last_exp   <= '0;
            o_nb_ok      <= '0;
            o_nb_err     <= '0;
        end else begin
            o_match      <= cmp && !data_ne;
            o_mismatch   <= cmp && data_ne;
            o_parity_err <= par_bad;
            o_unexpected <= unexp;
            o_timeout    <= tmo_hit;
            if (i_exp_valid && full) o_overflow <= 1'b1;
            if (rx_live) o_last_rcvd <= i_rx_data;
            if (pop) o_last_exp <= head;
            if (cmp && !data_ne && o_nb_ok != 16'hFFFF) begin
                o_nb_ok <= o_nb_ok + 16'd1;
            end
            o_nb_err <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            unique case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (push_en) state <= WAIT_RX;
                end
                WAIT_RX: begin
                    tmo_cnt <= (i_rx_done || tmo_hit) ? '0 : tmo_cnt + 32'd1;
                    if (pop && !push_en && o_level == LW'(1)) state <= IDLE;
                end
                HALT: tmo_cnt <= '0;
                default: state <= IDLE;
            endcase
            if (G_STOP_ON_ERR != 0 && n_err != 2'd0) state <= HALT;
        end
    end

endmodule

// File: tb/tb_uart_rx_scoreboard.sv
// Bench for uart_rx_scoreboard: vector table, corner sequences, random vs queue model.
module tb_uart_rx_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data = 8'h00;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       par = 1'b0;

    logic        ready_a, match_a, mism_a, pe_a, unexp_a, tmo_a, ovf_a, halt_a;
    logic [7:0]  lr_a, le_a;
    logic [15:0] ok_a, err_a;
    logic [4:0]  lvl_a;

    logic        ready_b, match_b, mism_b, pe_b, unexp_b, tmo_b, ovf_b, halt_b;
    logic [7:0]  lr_b, le_b;
    logic [15:0] ok_b, err_b;
    logic [2:0]  lvl_b;

    always #5 clk = ~clk;

    uart_rx_scoreboard #(
        .G_DATA_WIDTH(8), .G_FIFO_DEPTH(16), .G_PARITY(1),
        .G_TIMEOUT_CYCLES(100), .G_STOP_ON_ERR(0)
    ) u_a (
        .clk(clk), .rst(rst), .i_clr(clr),
        .i_exp_valid(exp_valid), .i_exp_data(exp_data), .o_exp_ready(ready_a),
        .i_rx_done(rx_done), .i_rx_data(rx_data), .i_parity_rcvd(par),
        .o_match(match_a), .o_mismatch(mism_a), .o_parity_err(pe_a),
        .o_unexpected(unexp_a), .o_timeout(tmo_a), .o_overflow(ovf_a),
        .o_halted(halt_a), .o_last_rcvd(lr_a), .o_last_exp(le_a),
        .o_nb_ok(ok_a), .o_nb_err(err_a), .o_level(lvl_a)
    );

    uart_rx_scoreboard #(
        .G_DATA_WIDTH(8), .G_FIFO_DEPTH(4), .G_PARITY(2),
        .G_TIMEOUT_CYCLES(0), .G_STOP_ON_ERR(1)
    ) u_b (
        .clk(clk), .rst(rst), .i_clr(clr),
        .i_exp_valid(exp_valid), .i_exp_data(exp_data), .o_exp_ready(ready_b),
        .i_rx_done(rx_done), .i_rx_data(rx_data), .i_parity_rcvd(par),
        .o_match(match_b), .o_mismatch(mism_b), .o_parity_err(pe_b),
        .o_unexpected(unexp_b), .o_timeout(tmo_b), .o_overflow(ovf_b),
        .o_halted(halt_b), .o_last_rcvd(lr_b), .o_last_exp(le_b),
        .o_nb_ok(ok_b), .o_nb_err(err_b), .o_level(lvl_b)
    );

    typedef struct {
        bit       ev;
        bit [7:0] ed;
        bit       rd;
        bit [7:0] rdat;
        bit       par;
        bit [3:0] pl;
        int       lvl;
        int       ok;
        int       err;
        bit [7:0] lr;
        bit [7:0] le;
    } vec_t;

    vec_t vt[19];
    int   n_vec = 0;
    int   n_bad = 0;

    logic [7:0] mq[$];
    int         m_wait, m_ok, m_err, m_sz, m_e;
    bit         m_ovf, m_busy, slow;
    bit [4:0]   m_pl;
    logic [7:0] m_lr, m_le;
    int         hit;
    bit         seen;

    function automatic vec_t mk(bit ev, bit [7:0] ed, bit rd, bit [7:0] rdat,
                                bit p, bit [3:0] pl, int lvl, int ok, int err,
                                bit [7:0] lr, bit [7:0] le);
        vec_t v;
        v.ev = ev; v.ed = ed; v.rd = rd; v.rdat = rdat; v.par = p;
        v.pl = pl; v.lvl = lvl; v.ok = ok; v.err = err; v.lr = lr; v.le = le;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        exp_valid = 1'b0;
        rx_done   = 1'b0;
        clr       = 1'b0;
    endtask

    task automatic pulse_clr();
        quiet();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        exp_valid = 1'b1;
        exp_data  = d;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic recv(input logic [7:0] d, input logic p);
        rx_done = 1'b1;
        rx_data = d;
        par     = p;
        tick();
        rx_done = 1'b0;
    endtask

    initial begin
        // even-parity table on u_a; pulse order {match, mismatch, par_err, unexpected}
        vt[0]  = mk(1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 4'b0000, 1, 0, 0, 8'h00, 8'h00);
        vt[1]  = mk(1'b1, 8'hA3, 1'b0, 8'h00, 1'b0, 4'b0000, 2, 0, 0, 8'h00, 8'h00);
        vt[2]  = mk(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 4'b0000, 3, 0, 0, 8'h00, 8'h00);
        vt[3]  = mk(1'b0, 8'h00, 1'b1, 8'h55, 1'b0, 4'b1000, 2, 1, 0, 8'h55, 8'h55);
        vt[4]  = mk(1'b0, 8'h00, 1'b1, 8'hA3, 1'b0, 4'b1000, 1, 2, 0, 8'hA3, 8'hA3);
        vt[5]  = mk(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 4'b1000, 0, 3, 0, 8'h00, 8'h00);
        vt[6]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 4'b0000, 0, 3, 0, 8'h00, 8'h00);
        vt[7]  = mk(1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 4'b0000, 1, 3, 0, 8'h00, 8'h00);
        vt[8]  = mk(1'b0, 8'h00, 1'b1, 8'h3D, 1'b1, 4'b0100, 0, 3, 1, 8'h3D, 8'h3C);
        vt[9]  = mk(1'b1, 8'h07, 1'b0, 8'h00, 1'b0, 4'b0000, 1, 3, 1, 8'h3D, 8'h3C);
        vt[10] = mk(1'b0, 8'h00, 1'b1, 8'h07, 1'b0, 4'b1010, 0, 4, 2, 8'h07, 8'h07);
        vt[11] = mk(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 4'b0001, 0, 4, 3, 8'hFF, 8'h07);
        vt[12] = mk(1'b1, 8'h21, 1'b1, 8'h21, 1'b0, 4'b0001, 1, 4, 4, 8'h21, 8'h07);
        vt[13] = mk(1'b0, 8'h00, 1'b1, 8'h21, 1'b0, 4'b1000, 0, 5, 4, 8'h21, 8'h21);
        vt[14] = mk(1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 4'b0000, 1, 5, 4, 8'h21, 8'h21);
        vt[15] = mk(1'b1, 8'h20, 1'b1, 8'h10, 1'b1, 4'b1000, 1, 6, 4, 8'h10, 8'h10);
        vt[16] = mk(1'b0, 8'h00, 1'b1, 8'h20, 1'b1, 4'b1000, 0, 7, 4, 8'h20, 8'h20);
        vt[17] = mk(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 4'b0000, 1, 7, 4, 8'h20, 8'h20);
        vt[18] = mk(1'b0, 8'h00, 1'b1, 8'h5B, 1'b0, 4'b0110, 0, 7, 6, 8'h5B, 8'h5A);

        repeat (3) tick();
        rst = 1'b0;
        chk("reset_a",
            64'({match_a, mism_a, pe_a, unexp_a, tmo_a, ovf_a, halt_a, ready_a,
                 lvl_a, ok_a, err_a, lr_a, le_a}),
            64'({7'b0, 1'b1, 5'd0, 16'd0, 16'd0, 8'h00, 8'h00}));

        for (int i = 0; i < 19; i++) begin
            exp_valid = vt[i].ev;
            exp_data  = vt[i].ed;
            rx_done   = vt[i].rd;
            rx_data   = vt[i].rdat;
            par       = vt[i].par;
            tick();
            chk($sformatf("vec%0d", i),
                64'({match_a, mism_a, pe_a, unexp_a, tmo_a, halt_a, lvl_a,
                     ok_a, err_a, lr_a, le_a}),
                64'({vt[i].pl, 2'b00, 5'(vt[i].lvl), 16'(vt[i].ok),
                     16'(vt[i].err), vt[i].lr, vt[i].le}));
        end
        quiet();

        pulse_clr();
        chk("clr_a", 64'({ovf_a, ready_a, lvl_a, ok_a, err_a, lr_a, le_a}),
            64'({1'b0, 1'b1, 5'd0, 16'd0, 16'd0, 8'h00, 8'h00}));

        // timeout expiry 100 cycles after the push
        push(8'h11);
        hit = 0;
        for (int k = 1; k <= 150 && hit == 0; k++) begin
            tick();
            if (tmo_a) hit = k;
        end
        chk("tmo_latency", 64'(hit), 64'(100));
        chk("tmo_state", 64'({lvl_a, err_a, ok_a, le_a}),
            64'({5'd0, 16'd1, 16'd0, 8'h11}));
        tick();
        chk("tmo_one_pulse", 64'(tmo_a), 64'(0));

        // rx_done lands exactly on the expiry cycle
        pulse_clr();
        push(8'h11);
        seen = 1'b0;
        for (int k = 1; k <= 99; k++) begin
            tick();
            if (tmo_a) seen = 1'b1;
        end
        chk("tmo_early", 64'(seen), 64'(0));
        recv(8'h11, 1'b0);
        chk("tmo_vs_rx", 64'({match_a, tmo_a, lvl_a, ok_a, err_a}),
            64'({1'b1, 1'b0, 5'd0, 16'd1, 16'd0}));
        seen = 1'b0;
        for (int k = 0; k < 120; k++) begin
            tick();
            if (tmo_a) seen = 1'b1;
        end
        chk("tmo_idle", 64'(seen), 64'(0));

        // overflow, halt on error, clear (u_b: depth 4, odd parity, stop)
        pulse_clr();
        for (int i = 1; i <= 5; i++) push(8'(i));
        chk("ovf_b", 64'({ovf_b, lvl_b, ready_b}), 64'({1'b1, 3'd4, 1'b0}));
        recv(8'h99, 1'b1);
        chk("halt_b", 64'({mism_b, halt_b, err_b, lvl_b, le_b, lr_b}),
            64'({1'b1, 1'b1, 16'd1, 3'd3, 8'h01, 8'h99}));
        recv(8'h02, 1'b0);
        chk("halt_ignore_b",
            64'({match_b, mism_b, halt_b, ok_b, err_b, lvl_b, lr_b}),
            64'({1'b0, 1'b0, 1'b1, 16'd0, 16'd1, 3'd3, 8'h99}));
        push(8'h77);
        chk("halt_push_b", 64'(lvl_b), 64'(4));
        pulse_clr();
        chk("clr_b",
            64'({halt_b, ovf_b, ready_b, lvl_b, ok_b, err_b, lr_b, le_b}),
            64'({1'b0, 1'b0, 1'b1, 3'd0, 16'd0, 16'd0, 8'h00, 8'h00}));
        push(8'h42);
        recv(8'h42, 1'b1);
        chk("odd_ok_b", 64'({match_b, pe_b, halt_b, ok_b}),
            64'({1'b1, 1'b0, 1'b0, 16'd1}));
        push(8'h42);
        recv(8'h42, 1'b0);
        chk("odd_bad_b", 64'({match_b, pe_b, halt_b, err_b}),
            64'({1'b1, 1'b1, 1'b1, 16'd1}));

        // reset drops queued bytes
        pulse_clr();
        push(8'hAA);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        recv(8'hAA, 1'b0);
        chk("rst_mid_a", 64'({unexp_a, match_a, lvl_a, err_a}),
            64'({1'b1, 1'b0, 5'd0, 16'd1}));

        // random traffic on u_a against a queue model
        pulse_clr();
        mq.delete();
        m_wait = 0; m_ok = 0; m_err = 0; m_ovf = 1'b0;
        m_lr = 8'h00; m_le = 8'h00;
        slow = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) slow = ($urandom_range(0, 1) == 1);
            clr       = ($urandom_range(0, 299) == 0);
            exp_valid = ($urandom_range(0, 3) == 0);
            exp_data  = 8'($urandom);
            rx_done   = slow ? ($urandom_range(0, 249) == 0)
                             : ($urandom_range(0, 3) == 0);
            if (mq.size() > 0 && $urandom_range(0, 2) != 0) rx_data = mq[0];
            else rx_data = 8'($urandom);
            par = ($urandom_range(0, 4) == 0) ? !(^rx_data) : ^rx_data;

            m_pl = '0;
            if (clr) begin
                mq.delete();
                m_wait = 0; m_ok = 0; m_err = 0; m_ovf = 1'b0;
                m_lr = 8'h00; m_le = 8'h00;
            end else begin
                m_sz   = mq.size();
                m_busy = m_sz != 0;
                m_e    = 0;
                if (rx_done) begin
                    m_lr   = rx_data;
                    m_wait = 0;
                    if (par != ^rx_data) begin m_pl[2] = 1'b1; m_e++; end
                    if (m_busy) begin
                        m_le = mq.pop_front();
                        if (m_le == rx_data) begin
                            m_pl[4] = 1'b1;
                            if (m_ok < 65535) m_ok++;
                        end else begin
                            m_pl[3] = 1'b1;
                            m_e++;
                        end
                    end else begin
                        m_pl[1] = 1'b1;
                        m_e++;
                    end
                end else if (m_busy) begin
                    if (m_wait == 99) begin
                        m_pl[0] = 1'b1;
                        m_le    = mq.pop_front();
                        m_e++;
                        m_wait  = 0;
                    end else begin
                        m_wait++;
                    end
                end else begin
                    m_wait = 0;
                end
                if (exp_valid) begin
                    if (m_sz < 16) mq.push_back(exp_data);
                    else m_ovf = 1'b1;
                end
                m_err = (m_err + m_e > 65535) ? 65535 : m_err + m_e;
            end
            tick();
            chk($sformatf("rand%0d", c),
                64'({match_a, mism_a, pe_a, unexp_a, tmo_a, ovf_a, ready_a,
                     lvl_a, ok_a, err_a, lr_a, le_a}),
                64'({m_pl, m_ovf, mq.size() < 16, 5'(mq.size()),
                     16'(m_ok), 16'(m_err), m_lr, m_le}));
        end
        quiet();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
